// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_BASE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } dec_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       make;
        logic       ext;
    } key_evt_t;

    localparam logic [7:0]  PS2_EXT    = 8'hE0;
    localparam logic [7:0]  PS2_BRK    = 8'hF0;
    localparam logic [7:0]  PS2_PAUSE  = 8'hE1;
    localparam int unsigned PAUSE_SKIP = 7;
    localparam int unsigned FRAME_BITS = 11;

    localparam int unsigned NUM_NON_KEY = 6;
    localparam logic [NUM_NON_KEY-1:0][7:0] NON_KEY_BYTES =
        {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    // Status/ack bytes the keyboard sends that never represent a key.
    function automatic logic is_non_key(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_NON_KEY); i++) begin
            if (NON_KEY_BYTES[i] == b) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// PS/2 pad lines in, decoded key events out.
interface ps2_scancode_decoder_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] keycode;
    logic       key_make;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;

    modport master (
        input  ps2_clk, ps2_dat,
        output keycode, key_make, key_ext, key_valid, frame_err
    );

    modport slave (
        output ps2_clk, ps2_dat,
        input  keycode, key_make, key_ext, key_valid, frame_err
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// Synchronizes and filters the PS/2 lines and deserializes 11-bit frames
// with parity check and inter-edge watchdog.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned WD_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FLT_W       = $clog2(FILTER_LEN);
    localparam int unsigned BIT_W       = 4;

    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       dat_sync_q, dat_sync_d;
    logic             filt_q, filt_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_ok_q, par_ok_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_err_q, rx_err_d;
    logic             smp_c;
    logic             dat_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            flt_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_ok_q   <= 1'b0;
            wd_q       <= WD_W'(TIMEOUT_CYC - 1);
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            flt_cnt_q  <= flt_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_ok_q   <= par_ok_d;
            wd_q       <= wd_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_dat};
        filt_d     = filt_q;
        flt_cnt_d  = '0;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_ok_d   = par_ok_q;
        wd_d       = wd_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;

        // Level flips on the FILTER_LEN-th consecutive differing sample.
        if (clk_sync_q[1] != filt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
            else                                     flt_cnt_d = flt_cnt_q + FLT_W'(1);
        end
        smp_c = filt_q & ~filt_d;
        dat_c = dat_sync_q[1];

        if (smp_c) begin
            wd_d = WD_W'(TIMEOUT_CYC - 1);
            if (bit_cnt_q == '0) begin
                if (!dat_c) bit_cnt_d = BIT_W'(1);
                else        rx_err_d  = 1'b1;
            end else if (bit_cnt_q <= BIT_W'(8)) begin
                shreg_d   = {dat_c, shreg_q[7:1]};
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end else if (bit_cnt_q == BIT_W'(9)) begin
                par_ok_d  = ^{shreg_q, dat_c};
                bit_cnt_d = BIT_W'(FRAME_BITS - 1);
            end else begin
                bit_cnt_d = '0;
                if (par_ok_q && dat_c) begin
                    rx_byte_d  = shreg_q;
                    rx_valid_d = 1'b1;
                end else begin
                    rx_err_d = 1'b1;
                end
            end
        end else if (bit_cnt_q != '0) begin
            // Watchdog only runs while a frame is in progress.
            if (wd_q == '0) begin
                bit_cnt_d = '0;
                rx_err_d  = 1'b1;
                wd_d      = WD_W'(TIMEOUT_CYC - 1);
            end else begin
                wd_d = wd_q - WD_W'(1);
            end
        end
    end

    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Scan-code set 2 prefix decoder: turns received bytes into make/break
// key events with extended-key flag.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input logic                    clk,
    input logic                    reset,
    ps2_scancode_decoder_if.master bus
);

    localparam int unsigned SKIP_W = $clog2(PAUSE_SKIP + 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    dec_state_e        state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    key_evt_t          evt_q, evt_d;
    logic              key_valid_q, key_valid_d;

    ps2_frame_rx #(
        .CLK_HZ    (CLK_HZ),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_US(TIMEOUT_US)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (bus.ps2_clk),
        .ps2_dat (bus.ps2_dat),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BASE;
            skip_q      <= '0;
            evt_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            evt_q       <= evt_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        evt_d       = evt_q;
        key_valid_d = 1'b0;

        if (rx_err) begin
            state_d = ST_BASE;
            skip_d  = '0;
        end else if (rx_valid) begin
            if (state_q == ST_SKIP) begin
                // Swallow the remainder of the Pause sequence.
                skip_d = skip_q - SKIP_W'(1);
                if (skip_q == SKIP_W'(1)) state_d = ST_BASE;
            end else begin
                state_d = ST_BASE;
                if (state_q == ST_BASE && rx_byte == PS2_EXT) begin
                    state_d = ST_EXT;
                end else if (state_q == ST_BASE && rx_byte == PS2_BRK) begin
                    state_d = ST_BRK;
                end else if (state_q == ST_BASE && rx_byte == PS2_PAUSE) begin
                    state_d = ST_SKIP;
                    skip_d  = SKIP_W'(PAUSE_SKIP);
                end else if (state_q == ST_EXT && rx_byte == PS2_BRK) begin
                    state_d = ST_EXT_BRK;
                end else if (state_q == ST_EXT && rx_byte == PS2_EXT) begin
                    state_d = ST_EXT;
                end else if (state_q == ST_BRK && rx_byte == PS2_BRK) begin
                    state_d = ST_BRK;
                end else if (!is_non_key(rx_byte)) begin
                    evt_d.code  = rx_byte;
                    evt_d.make  = !(state_q == ST_BRK || state_q == ST_EXT_BRK);
                    evt_d.ext   = (state_q == ST_EXT || state_q == ST_EXT_BRK);
                    key_valid_d = 1'b1;
                end
            end
        end
    end

    assign bus.keycode   = evt_q.code;
    assign bus.key_make  = evt_q.make;
    assign bus.key_ext   = evt_q.ext;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = rx_err;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomized + directed bench for ps2_scancode_decoder against a flag-based reference model.
module tb_ps2_scancode_decoder;

    localparam int unsigned CLK_HZ     = 1_000_000;
    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned TIMEOUT_US = 60;
    localparam int          HALF       = 10;
    localparam int          GAP        = 30;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    ps2_scancode_decoder_if bus();

    ps2_scancode_decoder #(
        .CLK_HZ    (CLK_HZ),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         ev_cnt = 0, err_cnt = 0;
    int         ev_cyc = 0, err_cyc = 0, stop_cyc = 0;
    logic [7:0] ev_code;
    logic       ev_make, ev_ext;
    logic       both_seen = 1'b0;

    bit         m_ext, m_brk;
    int         m_skip;
    logic [7:0] nk [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    always @(negedge clk) begin
        if (bus.key_valid) begin
            ev_cnt++;
            ev_cyc  = cyc;
            ev_code = bus.keycode;
            ev_make = bus.key_make;
            ev_ext  = bus.key_ext;
        end
        if (bus.frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (bus.key_valid && bus.frame_err) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_dat = fr[i];
            bus.ps2_clk = 1'b1;
            repeat (HALF - 1) @(negedge clk);
            bus.ps2_clk = 1'b0;
            stop_cyc    = cyc;
            repeat (HALF) @(negedge clk);
        end
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input bit bad,
                         input bit exp_ev, input bit exp_err,
                         input logic [7:0] kc, input bit mk, input bit ex);
        int e0, r0;
        e0 = ev_cnt;
        r0 = err_cnt;
        send_bits(b, bad, 11);
        repeat (GAP) @(negedge clk);
        check({tag, "_ev"},  32'(ev_cnt - e0),  32'(exp_ev));
        check({tag, "_err"}, 32'(err_cnt - r0), 32'(exp_err));
        if (exp_ev) begin
            check({tag, "_code"}, 32'(ev_code), 32'(kc));
            check({tag, "_make"}, 32'(ev_make), 32'(mk));
            check({tag, "_ext"},  32'(ev_ext),  32'(ex));
        end
    endtask

    // Reference: prefix flags plus a pending-skip count.
    task automatic model(input logic [7:0] b, input bit bad,
                         output bit exp_ev, output bit exp_err,
                         output logic [7:0] kc, output bit mk, output bit ex);
        bool_nk: begin end
        exp_ev = 0; exp_err = 0; kc = 8'h00; mk = 0; ex = 0;
        if (bad) begin
            exp_err = 1; m_ext = 0; m_brk = 0; m_skip = 0;
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0 && !m_brk) begin
            m_ext = 1;
        end else if (b == 8'hF0 && !(m_ext && m_brk)) begin
            m_brk = 1;
        end else if (b == 8'hE1 && !m_ext && !m_brk) begin
            m_skip = 7;
        end else begin
            bit is_nk;
            is_nk = 0;
            for (int i = 0; i < 6; i++) if (nk[i] == b) is_nk = 1;
            if (!is_nk) begin
                exp_ev = 1; kc = b; mk = !m_brk; ex = m_ext;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        bit         ev, er, bad, mk, ex;
        logic [7:0] b, kc;
        int         r, e0, r0;
        logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_keycode", 32'(bus.keycode), 32'h0);
        check("rst_flags", 32'({bus.key_make, bus.key_ext, bus.key_valid, bus.frame_err}), 32'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        frame("w_press", 8'h1D, 0, 1, 0, 8'h1D, 1, 0);
        check("lat_event", 32'(ev_cyc - stop_cyc), 32'(FILTER_LEN + 3));

        frame("brk_pre", 8'hF0, 0, 0, 0, 8'h00, 0, 0);
        frame("brk_1d",  8'h1D, 0, 1, 0, 8'h1D, 0, 0);

        frame("e0_a",  8'hE0, 0, 0, 0, 8'h00, 0, 0);
        frame("e0_75", 8'h75, 0, 1, 0, 8'h75, 1, 1);
        frame("e0_b",  8'hE0, 0, 0, 0, 8'h00, 0, 0);
        frame("e0f0",  8'hF0, 0, 0, 0, 8'h00, 0, 0);
        frame("e0f0_75", 8'h75, 0, 1, 0, 8'h75, 0, 1);

        frame("par_e0", 8'hE0, 0, 0, 0, 8'h00, 0, 0);
        frame("par_bad", 8'h1D, 1, 0, 1, 8'h00, 0, 0);
        check("lat_err", 32'(err_cyc - stop_cyc), 32'(FILTER_LEN + 2));
        frame("par_1d", 8'h1D, 0, 1, 0, 8'h1D, 1, 0);

        // Watchdog: partial frame then a silent line.
        e0 = ev_cnt; r0 = err_cnt;
        send_bits(8'h12, 0, 5);
        repeat (100) @(negedge clk);
        check("wd_err", 32'(err_cnt - r0), 32'd1);
        check("wd_ev", 32'(ev_cnt - e0), 32'd0);
        frame("wd_1c", 8'h1C, 0, 1, 0, 8'h1C, 1, 0);

        // Sub-threshold glitch on an idle line must not start a frame.
        r0 = err_cnt;
        @(negedge clk); bus.ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (GAP) @(negedge clk);
        check("glitch_err", 32'(err_cnt - r0), 32'd0);

        e0 = ev_cnt; r0 = err_cnt;
        for (int i = 0; i < 8; i++) begin
            send_bits(pause_seq[i], 0, 11);
            repeat (GAP) @(negedge clk);
        end
        check("pause_ev", 32'(ev_cnt - e0), 32'd0);
        check("pause_err", 32'(err_cnt - r0), 32'd0);

        // Asynchronous reset in the middle of a frame.
        send_bits(8'h55, 0, 5);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_keycode", 32'(bus.keycode), 32'h0);
        check("mid_rst_flags", 32'({bus.key_make, bus.key_ext, bus.key_valid, bus.frame_err}), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        frame("post_rst_29", 8'h29, 0, 1, 0, 8'h29, 1, 0);

        m_ext = 0; m_brk = 0; m_skip = 0;
        for (int k = 0; k < 120; k++) begin
            r   = $urandom_range(0, 99);
            bad = 0;
            if      (r < 15) b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else if (r < 32) b = 8'hE1;
            else if (r < 40) b = nk[$urandom_range(0, 5)];
            else begin
                b   = 8'($urandom_range(0, 255));
                bad = (r >= 92);
            end
            model(b, bad, ev, er, kc, mk, ex);
            frame("rnd", b, bad, ev, er, kc, mk, ex);
        end

        check("strobe_excl", 32'(both_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
